c_velocidad: RTL and testbench

- Automatic 6-speed gearbox controller with a "race mode" sensor FSM and a timer/indicator selector, in one clocked block.
- Race-mode FSM (MC) turns track sensors into automatic accelerate (A) and decelerate (D) requests.
- Gearbox FSM merges A/D with the manual pedals (AM/DM) and steps gears 0..6. Gear changes are paced by external per-gear timers.
- Selector decodes the timer-enable code into one-hot timer-enable outputs and a gear display.

---
 rtl/c_velocidad_pkg.sv | 31 +++
 rtl/c_velocidad_sel.sv | 20 ++
 rtl/c_velocidad.sv | 123 ++++++++++++
 tb/tb_c_velocidad.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/c_velocidad_pkg.sv
// Shared encodings for the 6-speed gearbox controller: gear states, race-mode
// states and surrounding-car codes.
package c_velocidad_pkg;

    localparam int NGEAR_DEF   = 6;
    localparam int SV_GEAR_DEF = 3;

    // Gear state encoding equals the displayed gear, so S_C_V doubles as VA.
    typedef enum logic [3:0] {
        PARK = 4'd0,
        G1   = 4'd1,
        G2   = 4'd2,
        G3   = 4'd3,
        G4   = 4'd4,
        G5   = 4'd5,
        G6   = 4'd6
    } gear_e;

    typedef enum logic [1:0] {
        MC_OFF  = 2'b00,
        MC_WAIT = 2'b01,
        MC_RUN  = 2'b10,
        MC_CRIT = 2'b11
    } mc_e;

    localparam logic [1:0] SP_NONE   = 2'b00;
    localparam logic [1:0] SP_FRONT  = 2'b01;
    localparam logic [1:0] SP_SIDE   = 2'b10;
    localparam logic [1:0] SP_BEHIND = 2'b11;

endpackage

// File: rtl/c_velocidad_sel.sv
// Timer/indicator selector: one-hot timer LEDs from the upshift timer select
// and a one-hot gear display, both blanked when the display is disabled.
module c_velocidad_sel
    import c_velocidad_pkg::*;
(
    input  logic       i_en,
    input  logic [2:0] i_et,
    input  logic [2:0] i_va,
    output logic [4:0] o_led,
    output logic [5:0] o_dec
);

    always_comb begin
        o_led = '0;
        o_dec = '0;
        for (int k = 1; k <= 5; k++) o_led[k-1] = i_en && (i_et == 3'(k));
        for (int k = 1; k <= 6; k++) o_dec[k-1] = i_en && (i_va == 3'(k));
    end

endmodule

// File: rtl/c_velocidad.sv
// Automatic 6-speed gearbox with race-mode sensor FSM. Gear steps are paced by
// external per-gear timers; the selector drives the LEDs and gear display.
module c_velocidad
    import c_velocidad_pkg::*;
#(
    parameter int NGEAR   = NGEAR_DEF,
    parameter int SV_GEAR = SV_GEAR_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RF,
    input  logic       TM,
    input  logic       SC,
    input  logic [1:0] SP,
    input  logic       E,
    input  logic       AM,
    input  logic       DM,
    input  logic       EnD,
    input  logic       T1,
    input  logic       T2,
    input  logic       T3,
    input  logic       T4,
    input  logic       T5,
    input  logic       TD,
    output logic [2:0] VA,
    output logic [2:0] ET,
    output logic       SV,
    output logic       ETD,
    output logic       TimerLED1,
    output logic       TimerLED2,
    output logic       TimerLED3,
    output logic       TimerLED4,
    output logic       TimerLED5,
    output logic [5:0] dec,
    output logic       A,
    output logic       D,
    output logic [1:0] S_MC,
    output logic [3:0] S_C_V
);

    gear_e       r_gear, w_gear_nxt;
    mc_e         r_mc, w_mc_nxt;
    logic        w_up, w_down, w_crit, w_etd;
    logic [2:0]  w_et;
    logic [7:0]  w_tsel;
    logic [4:0]  w_led;

    assign VA    = r_gear[2:0];
    assign S_C_V = r_gear;
    assign S_MC  = r_mc;
    assign SV    = (VA > 3'(SV_GEAR));
    assign ET    = w_et;
    assign ETD   = w_etd;

    // Manual accel beats auto decel; manual decel beats auto accel.
    assign w_up   = (AM | A) & ~DM & ~D;
    assign w_down = (DM | D) & ~AM;
    assign w_crit = SC | (TM & ~RF);

    // Bit k holds timer k, so indexing by ET picks only the selected timer.
    assign w_tsel = {2'b00, T5, T4, T3, T2, T1, 1'b0};

    // Gearbox FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_gear <= PARK;
        else      r_gear <= w_gear_nxt;
    end

    always_comb begin
        w_gear_nxt = r_gear;
        if (w_up && r_gear == PARK)        w_gear_nxt = G1;
        else if (w_et != 3'd0 && w_tsel[w_et]) w_gear_nxt = gear_e'(r_gear + 4'd1);
        else if (w_etd && TD)              w_gear_nxt = gear_e'(r_gear - 4'd1);
    end

    always_comb begin
        w_et  = '0;
        w_etd = 1'b0;
        if (w_up && VA != 3'd0 && VA < 3'(NGEAR)) w_et = VA;
        if (w_down && VA != 3'd0)                 w_etd = 1'b1;
    end

    // Race-mode FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_mc <= MC_OFF;
        else      r_mc <= w_mc_nxt;
    end

    always_comb begin
        w_mc_nxt = r_mc;
        if (!E) w_mc_nxt = MC_OFF;
        else begin
            case (r_mc)
                MC_OFF:  w_mc_nxt = (VA == 3'd0) ? MC_WAIT : MC_RUN;
                MC_WAIT: if (SP != SP_NONE) w_mc_nxt = MC_RUN;
                MC_RUN:  if (w_crit) w_mc_nxt = MC_CRIT;
                MC_CRIT: if (!w_crit) w_mc_nxt = MC_RUN;
                default: w_mc_nxt = MC_OFF;
            endcase
        end
    end

    // Auto decel stops at SV_GEAR; a curve with a car behind holds the gear.
    always_comb begin
        A = E && (r_mc == MC_RUN);
        D = E && (r_mc == MC_CRIT) && SV && !(SC && SP == SP_BEHIND);
    end

    c_velocidad_sel u_sel (
        .i_en  (EnD),
        .i_et  (w_et),
        .i_va  (VA),
        .o_led (w_led),
        .o_dec (dec)
    );

    assign TimerLED1 = w_led[0];
    assign TimerLED2 = w_led[1];
    assign TimerLED3 = w_led[2];
    assign TimerLED4 = w_led[3];
    assign TimerLED5 = w_led[4];

endmodule

// File: tb/tb_c_velocidad.sv
// Bench for c_velocidad: scripted scenarios plus random stimulus, all checked
// every cycle against a gear/race-mode model kept as plain integers.
module tb_c_velocidad;

    logic       clk, rst, RF, TM, SC, E, AM, DM, EnD, TD;
    logic [1:0] SP;
    logic [6:0] tt;
    logic [2:0] VA, ET;
    logic       SV, ETD, A, D;
    logic       TimerLED1, TimerLED2, TimerLED3, TimerLED4, TimerLED5;
    logic [5:0] dec;
    logic [1:0] S_MC;
    logic [3:0] S_C_V;

    int n_tot = 0;
    int n_bad = 0;
    int m_gear = 0;
    int m_mc = 0;   // 0 off, 1 wait, 2 run, 3 crit

    c_velocidad dut (
        .clk(clk), .rst(rst), .RF(RF), .TM(TM), .SC(SC), .SP(SP), .E(E),
        .AM(AM), .DM(DM), .EnD(EnD),
        .T1(tt[1]), .T2(tt[2]), .T3(tt[3]), .T4(tt[4]), .T5(tt[5]), .TD(TD),
        .VA(VA), .ET(ET), .SV(SV), .ETD(ETD),
        .TimerLED1(TimerLED1), .TimerLED2(TimerLED2), .TimerLED3(TimerLED3),
        .TimerLED4(TimerLED4), .TimerLED5(TimerLED5),
        .dec(dec), .A(A), .D(D), .S_MC(S_MC), .S_C_V(S_C_V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Called right after a negedge with inputs already applied: checks all
    // outputs against the model, then advances one clock.
    task automatic step();
        int crit, a, d, sv, up, dn, et, etd, gn, mn, led, dcx;
        if (!rst) begin m_gear = 0; m_mc = 0; end
        #2;
        crit = int'(SC || (TM && !RF));
        sv   = int'(m_gear > 3);
        a    = int'(E && m_mc == 2);
        d    = int'(E && m_mc == 3 && sv != 0 && !(SC && SP == 2'b11));
        up   = int'((AM || a != 0) && !DM && d == 0);
        dn   = int'((DM || d != 0) && !AM);
        et   = (up != 0 && m_gear >= 1 && m_gear <= 5) ? m_gear : 0;
        etd  = int'(dn != 0 && m_gear > 0);
        led  = (EnD && et != 0) ? (1 << (et - 1)) : 0;
        dcx  = (EnD && m_gear != 0) ? (1 << (m_gear - 1)) : 0;
        chk("va", 32'(VA), m_gear);
        chk("scv", 32'(S_C_V), m_gear);
        chk("smc", 32'(S_MC), m_mc);
        chk("a", 32'(A), a);
        chk("d", 32'(D), d);
        chk("sv", 32'(SV), sv);
        chk("et", 32'(ET), et);
        chk("etd", 32'(ETD), etd);
        chk("led", 32'({TimerLED5, TimerLED4, TimerLED3, TimerLED2, TimerLED1}), led);
        chk("dec", 32'(dec), dcx);
        gn = m_gear;
        if (up != 0 && m_gear == 0)      gn = 1;
        else if (et != 0 && tt[et])      gn = m_gear + 1;
        else if (etd != 0 && TD)         gn = m_gear - 1;
        if (!E) mn = 0;
        else if (m_mc == 0) mn = (m_gear == 0) ? 1 : 2;
        else if (m_mc == 1) mn = (SP != 2'b00) ? 2 : 1;
        else                mn = (crit != 0) ? 3 : 2;
        @(posedge clk);
        #1;
        if (rst) begin m_gear = gn; m_mc = mn; end
        else     begin m_gear = 0;  m_mc = 0;  end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b1; RF = 0; TM = 0; SC = 0; SP = 2'b00; E = 0;
        AM = 0; DM = 0; EnD = 1; TD = 0; tt = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    // Manual upshift to a target gear, pulsing exactly the timer ET selects.
    task automatic climb(input int target);
        AM = 1; DM = 0; E = 0;
        for (int i = 0; i < 20 && m_gear < target; i++) begin
            tt = 7'(1 << m_gear);
            step();
        end
        tt = '0;
        chk("climb", 32'(VA), target);
    endtask

    initial begin
        idle();
        rst = 1'b0;
        step();
        step();
        chk("rst_va", 32'(VA), 0);
        chk("rst_dec", 32'(dec), 0);
        rst = 1'b1;

        // Full upshift, then hold at top gear
        climb(6);
        AM = 1; tt = 7'h7e;
        step();
        chk("top_hold", 32'(VA), 6);
        AM = 0;
        for (int i = 0; i < 3; i++) step();

        // Manual downshift to park
        DM = 1; TD = 1;
        for (int i = 0; i < 8; i++) step();
        chk("down_park", 32'(VA), 0);
        DM = 0; TD = 0;

        // AM+DM conflict holds
        climb(3);
        AM = 1; DM = 1; TD = 1; tt = 7'h7e;
        for (int i = 0; i < 3; i++) step();
        chk("conflict", 32'(VA), 3);
        idle();

        // Async reset mid-shift
        climb(4);
        tt = 7'h10;
        rst = 1'b0;
        #1;
        chk("arst_va", 32'(VA), 0);
        chk("arst_et", 32'(ET), 0);
        step();
        do_reset();

        // Race start: wait for a car, then go
        E = 1; SP = 2'b00;
        for (int i = 0; i < 3; i++) step();
        chk("race_wait", 32'(S_MC), 1);
        SP = 2'b01;
        step();
        chk("race_run", 32'(A), 1);
        step();
        chk("race_g1", 32'(VA), 1);
        do_reset();

        // Critical decel stops at SV_GEAR, AM holds, DM goes on to park
        climb(6);
        AM = 0; E = 1; TM = 1; TD = 1;
        for (int i = 0; i < 10; i++) step();
        chk("crit_floor", 32'(VA), 3);
        AM = 1;
        for (int i = 0; i < 3; i++) step();
        chk("crit_am", 32'(VA), 3);
        AM = 0; DM = 1;
        for (int i = 0; i < 6; i++) step();
        chk("crit_dm", 32'(VA), 0);
        do_reset();

        // Curve with car behind holds; clearing the car resumes decel
        climb(5);
        AM = 0; E = 1; SC = 1; SP = 2'b11; TD = 1;
        for (int i = 0; i < 4; i++) step();
        chk("curve_hold", 32'(VA), 5);
        SP = 2'b00;
        for (int i = 0; i < 2; i++) step();
        chk("curve_dec", 32'(VA), 3);
        SC = 0; RF = 1; TM = 1;
        for (int i = 0; i < 2; i++) step();
        chk("rf_run", 32'(A), 1);
        do_reset();

        // Random traffic with occasional async reset
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) != 0);
            RF  = 1'($urandom);
            TM  = ($urandom_range(0, 3) == 0);
            SC  = ($urandom_range(0, 3) == 0);
            SP  = 2'($urandom);
            E   = ($urandom_range(0, 7) != 0);
            AM  = 1'($urandom);
            DM  = ($urandom_range(0, 2) == 0);
            EnD = ($urandom_range(0, 4) != 0);
            TD  = 1'($urandom);
            tt  = 7'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
